muldiv_unit: RTL and testbench

- Iterative multiply/divide sequencer executing MULT, MULTU, DIV and DIVU for the multi-cycle MIPS core. It sits beside the combinational ALU and owns the architectural HI/LO registers.
- The main control FSM issues a one-cycle start, then stalls on busy until done. It also services MTHI/MTLO writes.
- MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// An accepted start latches the operand magnitudes and sign flags. WIDTH
// iterations of shift-add or restoring shift-subtract follow, then one fix-up
// cycle applies sign correction and writes HI/LO. The result is visible
// 34 cycles after the start edge when WIDTH is 32.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op         one-cycle request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b      rs (multiplicand/dividend), rt (multiplier/divisor)
//   hi_we, lo_we      MTHI/MTLO strobes, honoured only while idle
//   wdata             MTHI/MTLO data
//   busy, done        operation in progress / one-cycle result-written pulse
//   hi, lo            architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_m;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_a_orig;  // raw dividend, returned in HI on divide by zero
    logic               r_is_div;
    logic               r_dz;
    logic               r_neg_q;   // operand signs differ (signed ops only)
    logic               r_neg_r;   // dividend negative (signed ops only)
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand preparation for the start edge. Negating 0x80000000 yields
    // 0x80000000, which read as unsigned is exactly the 2^31 magnitude.
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & src_a[WIDTH-1];
    assign w_b_neg  = w_signed & src_b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -src_a : src_a;
    assign w_mag_b  = w_b_neg ? -src_b : src_b;

    // One multiply step: conditionally add the multiplicand into the high
    // half, then shift the whole accumulator right with the carry.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);

    // One restoring divide step: trial-subtract the divisor from the
    // remainder shifted left by one. Bit WIDTH set means a borrow occurred.
    logic [WIDTH:0] w_trial;
    assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};

    // Sign fix-up for the FIX state.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_m      <= '0;
            r_a_orig <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // MTHI/MTLO; a result landing at FIX overwrites these.
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_dz     <= op[1] && (src_b == '0);
                        r_a_orig <= src_a;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_m      <= op[1] ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        if (w_trial[WIDTH])
                            r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                        else
                            r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_dz) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations,
// compared against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS semantics straight from signed/unsigned 64-bit arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        eh = p[63:32];
        el = p[31:0];
    endtask

    // mode 0: plain op; 1: extra start at cycle 10 (ignored);
    // 2: hi_we at cycle 10 (ignored); 3: rst at cycle 10 (abort).
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int mode);
        logic [31:0] eh, el, hi0;
        int done_cyc, ndone;
        bit busy_ok;
        model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        hi0 = hi; done_cyc = -1; ndone = 0; busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (mode != 3) begin
                if (n <= 33 && !busy) busy_ok = 1'b0;
                if (n >= 34 && busy)  busy_ok = 1'b0;
                if (n == 20) chk({tag, "/hold"}, {32'd0, hi}, {32'd0, hi0});
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (mode == 3 && n == 11) begin
                chk({tag, "/abort_busy"}, {63'd0, busy}, 64'd0);
                chk({tag, "/abort_hilo"}, {hi, lo}, 64'd0);
            end
            start = 1'b0; hi_we = 1'b0; rst = 1'b0;
            if (n == 10) begin
                case (mode)
                    1: begin start = 1'b1; op = ~o; src_a = 32'd99; src_b = 32'd3; end
                    2: begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        if (mode == 3) begin
            chk({tag, "/no_done"}, 64'(ndone), 64'd0);
        end else begin
            chk({tag, "/latency"}, 64'(done_cyc), 64'd34);
            chk({tag, "/ndone"}, 64'(ndone), 64'd1);
            chk({tag, "/busy"}, {63'd0, busy_ok}, 64'd1);
            chk({tag, "/result"}, {hi, lo}, {eh, el});
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset", {30'd0, busy, done, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;

        // Model sanity on hand-derived values.
        begin
            logic [31:0] h, l;
            model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l);
            chk("model_multu", {h, l}, 64'hFFFF_FFFE_0000_0001);
            model(2'b10, 32'hFFFF_FFF9, 32'd2, h, l);
            chk("model_div", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
        end

        do_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max_abs", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("mult_n3x7",  2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        chk("mult_n3x7_abs", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("mult_min2",  2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        chk("mult_min2_abs", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op("div_n7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_n7_2_abs", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_7_2",   2'b11, 32'd7, 32'd2, 0);
        chk("divu_7_2_abs", {hi, lo}, 64'h0000_0001_0000_0003);
        do_op("div_7_n2",   2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        chk("div_7_n2_abs", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        do_op("divu_by0",   2'b11, 32'h1234, 32'd0, 0);
        chk("divu_by0_abs", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        do_op("div_by0",    2'b10, 32'hFFFF_FFF0, 32'd0, 0);
        do_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_abs", {hi, lo}, 64'h0000_0000_8000_0000);

        do_op("ign_start",  2'b01, 32'd5, 32'd6, 1);
        chk("ign_start_lo", {32'd0, lo}, 64'd30);
        do_op("ign_hiwe",   2'b00, 32'd1000, 32'hFFFF_FF00, 2);
        do_op("abort",      2'b01, 32'd5, 32'd6, 3);

        // Idle MTLO / MTHI.
        @(negedge clk); lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk); lo_we = 1'b0;
        chk("mtlo", {32'd0, lo}, 64'hA5A5_A5A5);
        hi_we = 1'b1; wdata = 32'h5A5A_0001;
        @(negedge clk); hi_we = 1'b0;
        chk("mthi", {hi, lo}, 64'h5A5A_0001_A5A5_A5A5);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 9));
                1: rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), ro, ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
